conv2d_stream_engine: RTL

//   Next-generation streaming 2-D convolver: KxK kernel slides over an IMG_W x IMG_H raster-ordered

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_line_buffer.sv | 29 ++
 rtl/conv2d_stream_engine.sv | 127 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: state encoding and geometry helpers shared by the streaming convolver.
package conv_pkg;
  typedef enum logic [1:0] {LOAD, RUN, DRAIN, IDLE} state_t;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction
  function automatic int lb_depth(input int w, input int k);
    return (k - 1) * w + k;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: pixel shift chain exposing the KxK window whose bottom-right is the newest pixel.
module conv_line_buffer #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 4,
  parameter int K      = 3,
  parameter int DEPTH  = (K - 1) * IMG_W + K
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic [DATA_W-1:0]           din_i,
  output logic [K*K-1:0][DATA_W-1:0]  taps_o
);
  logic [DATA_W-1:0] sr_q [DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) sr_q[d] <= '0;
    end else if (en_i) begin
      sr_q[0] <= din_i;
      for (int d = 1; d < DEPTH; d++) sr_q[d] <= sr_q[d-1];
    end
  end
  // tap n = row*K+col; row 0 is the oldest line of the window
  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      assign taps_o[i*K+j] = sr_q[(K-1-i)*IMG_W + K-1-j];
    end
  end
endmodule

// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: streaming KxK convolver, serial weight load, 2-stage MAC pipeline.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              global_rst,
  input  logic              ce,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] activation,
  output logic              in_ready,
  output logic [ACC_W-1:0]  conv_op,
  output logic              valid_conv,
  input  logic              out_ready,
  output logic              out_last,
  output logic              end_conv
);
  localparam int KK       = K * K;
  localparam int OUT_COLS = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_ROWS = out_dim(IMG_H, K, STRIDE);
  localparam int LB_DEPTH = lb_depth(IMG_W, K);
  localparam int PROD_W   = 2 * DATA_W;
  localparam int LAST_R   = K - 1 + (OUT_ROWS - 1) * STRIDE;
  localparam int LAST_C   = K - 1 + (OUT_COLS - 1) * STRIDE;
  localparam int WCW      = clog2(KK);
  localparam int RW       = clog2(IMG_H);
  localparam int CW       = clog2(IMG_W);

  state_t state_q;
  logic [WCW-1:0] wcnt_q;
  logic [RW-1:0] r_q;
  logic [CW-1:0] c_q;
  logic signed [DATA_W-1:0] w_q [KK];
  logic signed [PROD_W-1:0] prod_q [KK];
  logic v0_q, l0_q, v1_q, l1_q, valid_q, last_q, end_q, seen_q;
  logic [ACC_W-1:0] conv_q;
  logic [KK-1:0][DATA_W-1:0] taps;
  logic [31:0] r, c;
  logic advance, w_acc, p_acc, o_acc, win, win_last, last_pix;
  logic signed [ACC_W-1:0] sum, res;

  assign r = 32'(r_q);
  assign c = 32'(c_q);
  assign advance = !(valid_q && !out_ready);
  assign w_ready = state_q == LOAD || state_q == IDLE;
  // a pending weight beat in IDLE takes priority over a new frame
  assign in_ready = (state_q == RUN || (state_q == IDLE && !w_valid)) && advance;
  assign w_acc = ce && w_valid && w_ready;
  assign p_acc = ce && in_valid && in_ready;
  assign o_acc = ce && valid_q && out_ready;
  assign win = r >= K - 1 && c >= K - 1 && (r - (K - 1)) % STRIDE == 0 && (c - (K - 1)) % STRIDE == 0;
  assign win_last = r == LAST_R && c == LAST_C;
  assign last_pix = r == IMG_H - 1 && c == IMG_W - 1;
  assign conv_op = conv_q;
  assign valid_conv = valid_q;
  assign out_last = last_q;
  assign end_conv = end_q;

  always_comb begin
    sum = '0;
    for (int n = 0; n < KK; n++) sum += ACC_W'(prod_q[n]);
  end

`ifdef CONV_RELU_EN
  assign res = sum[ACC_W-1] ? '0 : sum;
`else
  assign res = sum;
`endif

  conv_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .K(K), .DEPTH(LB_DEPTH)) u_lb (
    .clk(clk),
    .rst(global_rst),
    .en_i(p_acc),
    .din_i(activation),
    .taps_o(taps)
  );

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state_q <= LOAD;
      wcnt_q <= '0;
      r_q <= '0;
      c_q <= '0;
      for (int n = 0; n < KK; n++) begin
        w_q[n] <= '0;
        prod_q[n] <= '0;
      end
      {v0_q, l0_q, v1_q, l1_q, valid_q, last_q, end_q, seen_q} <= '0;
      conv_q <= '0;
    end else if (ce) begin
      if (w_acc) begin
        w_q[wcnt_q] <= w_data;
        wcnt_q <= (int'(wcnt_q) == KK - 1) ? '0 : wcnt_q + WCW'(1);
      end
      if (p_acc) begin
        c_q <= (c == IMG_W - 1) ? '0 : c_q + CW'(1);
        r_q <= (c != IMG_W - 1) ? r_q : (r == IMG_H - 1) ? '0 : r_q + RW'(1);
      end
      if (advance) begin
        v0_q <= p_acc && win;
        l0_q <= p_acc && win && win_last;
        v1_q <= v0_q;
        l1_q <= l0_q;
        for (int n = 0; n < KK; n++) prod_q[n] <= PROD_W'($signed(taps[n])) * PROD_W'(w_q[n]);
        valid_q <= v1_q;
        last_q <= l1_q;
        if (v1_q) conv_q <= res;
      end
      end_q <= o_acc && last_q;
      // the last result can leave before the frame's final pixel arrives when stride skips the tail
      seen_q <= (state_q == DRAIN) ? 1'b0 : seen_q || (o_acc && last_q);
      if (w_acc) state_q <= (int'(wcnt_q) == KK - 1) ? RUN : LOAD;
      else if (p_acc) state_q <= last_pix ? DRAIN : RUN;
      else if (state_q == DRAIN && (seen_q || (o_acc && last_q))) state_q <= IDLE;
    end
  end
endmodule
